uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: next generation of our fixed 8N1 receiver.
//  Configurable data width, oversampling ratio and stop-bit count; 3-sample majority vote at mid-bit.
//  Reports framing error and overrun, with valid/ack handshake. Optional parity checking.
//  Sits between the pad-side RXD line and the host-side command/FIFO logic in the rx_clk domain.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, legal 5..9, LSB first
//  OVERSAMPLE   16  rx_clk cycles per bit; even, >=8. M = OVERSAMPLE/2
//  STOP_BITS    1   stop bits expected, 1 or 2
//  SYNC_STAGES  2   rxd synchroniser depth, >=2
// PORTS
//  rx_clk      in   1          OVERSAMPLE x baud clock
//  reset_n     in   1          asynchronous, active-low reset
//  rxd         in   1          serial input, idle high, asynchronous
//  rx_ack      in   1          consumer accepts current word (sampled on rx_clk)
//  rx_data     out  DATA_BITS  received word, stable while rx_valid=1
//  rx_valid    out  1          word available; held until acked
//  frame_err   out  1          stop-bit vote was 0 for this word; qualified by rx_valid
//  overrun     out  1          a word was overwritten before ack; sticky until ack
//  parity_odd  in   1          (UART_RX_PARITY_EN only) 1 = odd parity, 0 = even
//  parity_err  out  1          (UART_RX_PARITY_EN only) parity mismatch; qualified by rx_valid
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0.
//    State=IDLE; counters=0; sync chain and prev-sample reg=1. Reset mid-frame discards the partial word.
//  - s = synchroniser output; p = s delayed one cycle. Bit counter cnt runs 0..OVERSAMPLE-1.
//  - Vote = majority of s sampled at cnt=M-1, M, M+1.
//  - IDLE: s==0 && p==1 -> START, cnt=0.
//  - START: decide at cnt=OVERSAMPLE-1.
//    - vote=1 -> IDLE; false start, no flags change.
//    - vote=0 -> DATA, bit_idx=0.
//  - DATA: decide each bit at cnt=OVERSAMPLE-1; shift vote in LSB first.
//    - After bit DATA_BITS-1 -> PARITY (macro) or STOP.
//  - PARITY: one bit period; check vote against the parity of the data bits.
//  - STOP: for STOP_BITS>1, non-final stop bits use the full period.
//    - Final stop bit decides early at cnt=M+1 so resync to the next start edge is possible.
//    - frame_err = OR of all stop votes == 0.
//    - frame_err=0 -> IDLE; frame_err=1 -> BREAK.
//  - BREAK: wait until s==1, then IDLE. A held-low line gives exactly one error word, with no re-trigger.
//  - Word delivery is registered on the cycle after the final stop decision.
//    - Loads rx_data, frame_err, parity_err; rx_valid=1.
//    - Words with frame_err or parity_err are still delivered.
//  - Latency: edge where rxd low is first clocked to rx_valid high
//    = SYNC_STAGES+1 + (DATA_BITS+1[+1 parity]+STOP_BITS-1)*OVERSAMPLE + M+1 edges.
//    Default 8N1: 156.
//  - Handshake: rx_ack && rx_valid -> rx_valid=0 and overrun=0 next cycle. rx_ack with rx_valid=0 is ignored.
//  - New word while rx_valid=1 and no ack: overwrite rx_data and flags, overrun=1, rx_valid stays 1.
//  - New word in the same cycle as ack: new word loaded, rx_valid stays 1, overrun=0.
//  - Counters wrap only through explicit reset to 0 at OVERSAMPLE-1; bit_idx never exceeds DATA_BITS-1.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Adds parity_odd, parity_err and the PARITY state.
//    - Expected parity bit = ^data ^ parity_odd.
//  UART_RX_PARITY_EN undefined:
//    - Ports absent, no PARITY state; frame = start+data+stop.
// TESTING
//  1 8N1 byte 0x55 at 16x -> rx_data=0x55, frame_err=0, rx_valid high 156 edges after the start edge.
//  2 Glitch: rxd low 5 cycles then high -> START vote=1, back to IDLE; rx_valid stays 0, no flags.
//  3 Byte 0xA3 with stop bit driven 0, then line held low 40 bit-times, then high -> exactly one word:
//    rx_data=0xA3, frame_err=1; no second word until line high and a new start.
//  4 Two bytes 0x01, 0x02 back-to-back, no ack -> rx_data=0x02, overrun=1.
//    Ack -> rx_valid=0, overrun=0 next cycle.
//  5 Ack asserted on the same cycle the second word lands -> rx_data=second word, rx_valid=1, overrun=0.
//  6 (UART_RX_PARITY_EN, parity_odd=0) 0x07 sent with parity bit 0 -> parity_err=1.
//    Same word with parity bit 1 -> parity_err=0.
//    Reset asserted mid-data -> all outputs 0; next clean frame received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: host-side word handshake of uart_rx_param; parity signals exist only with UART_RX_PARITY_EN.
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 rx_ack;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 parity_err;
    modport master (output rx_data, rx_valid, frame_err, overrun, parity_err, input rx_ack, parity_odd);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, parity_err, output rx_ack, parity_odd);
`else
    modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ack);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ack);
`endif
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, 3-sample mid-bit vote, framing/overrun flags, valid/ack handshake.
// Parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             rx_clk,
    input  logic             reset_n,
    input  logic             rxd,
    uart_rx_param_if.master  rx
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                 p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 stop_ok_q, stop_ok_d;
    logic [1:0]           smp_q, smp_d;
    logic                 vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif
    logic s, vote_now, bit_end, last_bit, done, any_ok, ack;

    assign s        = sync_q[SYNC_STAGES-1];
    assign vote_now = (smp_q[0] & smp_q[1]) | (smp_q[0] & s) | (smp_q[1] & s);
    assign bit_end  = cnt_q == CW'(OVERSAMPLE - 1);
    assign last_bit = bit_idx_q == BW'(DATA_BITS - 1);
    // The final stop bit is decided at mid-bit so a following start edge is not missed.
    assign done     = state_q == STOP && stop_idx_q == 1'(STOP_BITS - 1) && cnt_q == CW'(M + 1);
    assign any_ok   = vote_now | (STOP_BITS > 1 && stop_ok_q);
    assign ack      = rx.rx_ack && rx_valid_q;

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            p_q          <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            stop_ok_q    <= 1'b0;
            smp_q        <= '0;
            vote_q       <= 1'b0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            p_q          <= p_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            stop_ok_q    <= stop_ok_d;
            smp_q        <= smp_d;
            vote_q       <= vote_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!s && p_q) state_d = START;
            START:  if (bit_end) state_d = vote_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (bit_end && last_bit) state_d = PARITY;
            PARITY: if (bit_end) state_d = STOP;
`else
            DATA:   if (bit_end && last_bit) state_d = STOP;
`endif
            STOP:   if (done) state_d = any_ok ? IDLE : BREAK;
            BREAK:  if (s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], rxd};
        p_d          = s;
        cnt_d        = (state_q == IDLE || state_q == BREAK || done || bit_end) ? '0 : cnt_q + 1'b1;
        smp_d        = {cnt_q == CW'(M) ? s : smp_q[1], cnt_q == CW'(M - 1) ? s : smp_q[0]};
        vote_d       = cnt_q == CW'(M + 1) ? vote_now : vote_q;
        shift_d      = (state_q == DATA && bit_end) ? {vote_q, shift_q[DATA_BITS-1:1]} : shift_q;
        bit_idx_d    = state_q != DATA ? '0 : !bit_end ? bit_idx_q : last_bit ? '0 : bit_idx_q + 1'b1;
        stop_idx_d   = state_q != STOP ? 1'b0 : bit_end ? 1'b1 : stop_idx_q;
        stop_ok_d    = (state_q == STOP && bit_end) ? vote_q : stop_ok_q;
        rx_data_d    = done ? shift_q : rx_data_q;
        rx_valid_d   = done | (rx_valid_q & ~ack);
        frame_err_d  = done ? ~any_ok : frame_err_q;
        overrun_d    = done ? (rx_valid_q & ~ack) : (overrun_q & ~ack);
`ifdef UART_RX_PARITY_EN
        par_bad_d    = (state_q == PARITY && bit_end) ? (vote_q != (^shift_q ^ rx.parity_odd)) : par_bad_q;
        parity_err_d = done ? par_bad_q : parity_err_q;
`endif
    end

    assign rx.rx_data   = rx_data_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param at default parameters; covers UART_RX_PARITY_EN when defined.
module tb_uart_rx_param;
    localparam int DB   = 8;
    localparam int OS   = 16;
    localparam int STOP = 1;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT = SYNC + 1 + (DB + 1 + PAR + STOP - 1) * OS + OS / 2 + 1;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;

    logic rx_clk = 1'b0;
    logic reset_n = 1'b0;
    logic rxd = 1'b1;
    logic man_ack = 1'b0;
    logic auto_ack = 1'b0;
    logic auto_mode = 1'b1;
    logic parity_odd = 1'b0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   valid_cyc = 0;
    int   n_words = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    uart_rx_param_if #(.DATA_BITS(DB)) u_if ();
    assign u_if.rx_ack = auto_ack | man_ack;
`ifdef UART_RX_PARITY_EN
    assign u_if.parity_odd = parity_odd;
`endif

    uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(STOP), .SYNC_STAGES(SYNC)) dut (
        .rx_clk (rx_clk),
        .reset_n(reset_n),
        .rxd    (rxd),
        .rx     (u_if)
    );

    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge rx_clk) begin
        if (auto_mode && u_if.rx_valid && !auto_ack) begin
            exp_t e;
            n_words++;
            valid_cyc = cyc;
            if (sb.size() == 0) check("spurious_word", 1, 0);
            else begin
                e = sb.pop_front();
                check("rx_data", u_if.rx_data, e.data);
                check("frame_err", u_if.frame_err, e.ferr);
`ifdef UART_RX_PARITY_EN
                check("parity_err", u_if.parity_err, e.perr);
`endif
            end
            auto_ack = 1'b1;
        end else auto_ack = 1'b0;
    end

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic ferr, input logic par_flip);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.perr = par_flip;
        sb.push_back(e);
        @(negedge rx_clk);
        rxd = 1'b0;
        start_cyc = cyc + 1;
        repeat (OS) @(negedge rx_clk);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            repeat (OS) @(negedge rx_clk);
        end
        if (PAR == 1) begin
            rxd = ^d ^ parity_odd ^ par_flip;
            repeat (OS) @(negedge rx_clk);
        end
        rxd = stop_v;
        repeat (STOP * OS) @(negedge rx_clk);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge rx_clk);
        check("drain", sb.size(), 0);
        repeat (2) @(negedge rx_clk);
    endtask

    task automatic pulse_ack;
        man_ack = 1'b1;
        @(negedge rx_clk);
        man_ack = 1'b0;
    endtask

    initial begin
        exp_t e;
        int w0;
        repeat (4) @(negedge rx_clk);
        check("rst_valid", u_if.rx_valid, 0);
        check("rst_data", u_if.rx_data, 0);
        check("rst_ferr", u_if.frame_err, 0);
        check("rst_overrun", u_if.overrun, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge rx_clk);

        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        drain(LAT + 40);
        check("latency", valid_cyc - start_cyc, LAT);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        drain(LAT + 40);

        w0 = n_words;
        @(negedge rx_clk) rxd = 1'b0;
        repeat (5) @(negedge rx_clk);
        rxd = 1'b1;
        repeat (3 * OS) @(negedge rx_clk);
        check("glitch_valid", u_if.rx_valid, 0);
        check("glitch_words", n_words - w0, 0);

        w0 = n_words;
        send_frame(8'hA3, 1'b0, 1'b1, 1'b0);
        repeat (40 * OS) @(negedge rx_clk);
        rxd = 1'b1;
        repeat (3 * OS) @(negedge rx_clk);
        check("break_words", n_words - w0, 1);
        check("break_sb", sb.size(), 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        drain(LAT + 40);

        auto_mode = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        e = sb.pop_front();
        check("ovr_valid", u_if.rx_valid, 1);
        check("ovr_data", u_if.rx_data, e.data);
        check("ovr_flag", u_if.overrun, 1);
        pulse_ack();
        check("ovr_ack_valid", u_if.rx_valid, 0);
        check("ovr_ack_flag", u_if.overrun, 0);

        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        check("same_first", u_if.rx_data, e.data);
        fork
            send_frame(8'h22, 1'b1, 1'b0, 1'b0);
            begin
                @(negedge rx_clk);
                repeat (LAT) @(negedge rx_clk);
                pulse_ack();
                e = sb.pop_front();
                check("same_data", u_if.rx_data, e.data);
                check("same_valid", u_if.rx_valid, 1);
                check("same_overrun", u_if.overrun, 0);
                @(negedge rx_clk);
                check("same_hold", u_if.rx_valid, 1);
            end
        join
        pulse_ack();
        check("same_cleared", u_if.rx_valid, 0);
        auto_mode = 1'b1;

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        drain(LAT + 40);
`endif

        auto_mode = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front();
        check("pre_rst_data", u_if.rx_data, e.data);
        rxd = 1'b1;
        repeat (2 * OS) @(negedge rx_clk);
        rxd = 1'b0;
        repeat (4 * OS) @(negedge rx_clk);
        reset_n = 1'b0;
        @(negedge rx_clk);
        check("mid_rst_valid", u_if.rx_valid, 0);
        check("mid_rst_data", u_if.rx_data, 0);
        check("mid_rst_ferr", u_if.frame_err, 0);
`ifdef UART_RX_PARITY_EN
        check("mid_rst_perr", u_if.parity_err, 0);
`endif
        rxd = 1'b1;
        repeat (3) @(negedge rx_clk);
        reset_n = 1'b1;
        auto_mode = 1'b1;
        repeat (3) @(negedge rx_clk);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        drain(LAT + 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
